// File: rtl/corr_pkg.sv
// Shared types and helpers for the 2-gate correlation collector.
package corr_pkg;

    localparam int unsigned NUM_CLASSES = 16;
    localparam int unsigned CLASS_W     = 4;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDump,
        StDone
    } corr_state_e;

    // Class ignores masks r1/r2: only the unmasked a/b bits before and after matter.
    function automatic logic [CLASS_W-1:0] corr_class(input logic [3:0] pat_pre,
                                                      input logic [3:0] pat_post);
        return {pat_pre[3:2], pat_post[3:2]};
    endfunction

endpackage

// File: rtl/corr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module corr_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/correlation_2_collector.sv
// Bins masked-gadget toggle statistics per unmasked transition class, then streams 16 results.
// Optional order checker enabled by defining CORR_SEQ_CHECK_EN.
module correlation_2_collector
    import corr_pkg::*;
#(
    parameter int unsigned NUM_EXP = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [3:0]         s_pat_pre,
    input  logic [3:0]         s_pat_post,
    input  logic               s_y_pre,
    input  logic               s_y_post,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [CLASS_W-1:0] m_class,
    output logic [CNT_W-1:0]   m_count,
    output logic [CNT_W-1:0]   m_toggles,
    output logic               busy,
    output logic               done,
    output logic               seq_err
);

    corr_state_e        state_q, state_d;
    logic [15:0]        exp_q, exp_d;
    logic [CLASS_W-1:0] idx_q, idx_d;

    logic               hs;
    logic               clr;
    logic               last_exp;
    logic [CLASS_W-1:0] cls;
    logic [CNT_W-1:0]   cnt_w [NUM_CLASSES];
    logic [CNT_W-1:0]   tog_w [NUM_CLASSES];

    assign hs       = s_valid && s_ready;
    assign clr      = start && ((state_q == StIdle) || (state_q == StDone));
    assign last_exp = (exp_q == 16'(NUM_EXP - 1));
    assign cls      = corr_class(s_pat_pre, s_pat_post);

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_class
        corr_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (clr),
            .inc_i (hs && (cls == CLASS_W'(k))),
            .cnt_o (cnt_w[k])
        );
        corr_sat_counter #(.CNT_W(CNT_W)) u_tog (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (clr),
            .inc_i (hs && (cls == CLASS_W'(k)) && (s_y_pre ^ s_y_post)),
            .cnt_o (tog_w[k])
        );
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StCollect;
                    exp_d   = '0;
                    idx_d   = '0;
                end
            end
            StCollect: begin
                if (hs) begin
                    exp_d = exp_q + 16'd1;
                    if (last_exp) state_d = StDump;
                end
            end
            StDump: begin
                if (m_ready) begin
                    idx_d = idx_q + CLASS_W'(1);
                    if (idx_q == '1) state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            exp_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            idx_q   <= idx_d;
        end
    end

    assign s_ready   = (state_q == StCollect);
    assign m_valid   = (state_q == StDump);
    assign busy      = (state_q == StCollect) || (state_q == StDump);
    assign done      = (state_q == StDone);
    // Counters are frozen outside COLLECT, so the muxed registers hold during back-pressure.
    assign m_class   = m_valid ? idx_q : '0;
    assign m_count   = m_valid ? cnt_w[idx_q] : '0;
    assign m_toggles = m_valid ? tog_w[idx_q] : '0;

`ifdef CORR_SEQ_CHECK_EN
    logic seq_err_q, seq_err_d;

    // Experiment n is expected to carry pre = n[7:4], post = n[3:0].
    always_comb begin
        seq_err_d = seq_err_q;
        if (clr) begin
            seq_err_d = 1'b0;
        end else if (hs && ({s_pat_pre, s_pat_post} != exp_q[7:0])) begin
            seq_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_correlation_2_collector.sv
// Self-checking bench: behavioural class-bin model plus directed campaigns.
module tb_correlation_2_collector;

    localparam int unsigned CW     = 16;
    localparam int          SatMax = (1 << CW) - 1;
`ifdef CORR_SEQ_CHECK_EN
    localparam bit SeqEn = 1'b1;
`else
    localparam bit SeqEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start, s_valid, s_y_pre, s_y_post, m_ready;
    logic [3:0]    s_pat_pre, s_pat_post;
    logic          s_ready, m_valid, busy, done, seq_err;
    logic [3:0]    m_class;
    logic [CW-1:0] m_count, m_toggles;

    logic          start_b, s_valid_b, s_y_pre_b, s_y_post_b, m_ready_b;
    logic [3:0]    s_pat_pre_b, s_pat_post_b;
    logic          s_ready_b, m_valid_b, busy_b, done_b, seq_err_b;
    logic [3:0]    m_class_b;
    logic [1:0]    m_count_b, m_toggles_b;

    correlation_2_collector #(.NUM_EXP(256), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_pat_pre(s_pat_pre), .s_pat_post(s_pat_post), .s_y_pre(s_y_pre), .s_y_post(s_y_post),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_count(m_count),
        .m_toggles(m_toggles), .busy(busy), .done(done), .seq_err(seq_err)
    );

    correlation_2_collector #(.NUM_EXP(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .s_pat_pre(s_pat_pre_b), .s_pat_post(s_pat_post_b), .s_y_pre(s_y_pre_b),
        .s_y_post(s_y_post_b), .m_valid(m_valid_b), .m_ready(m_ready_b), .m_class(m_class_b),
        .m_count(m_count_b), .m_toggles(m_toggles_b), .busy(busy_b), .done(done_b),
        .seq_err(seq_err_b)
    );

    int checks = 0;
    int errors = 0;

    // Model: per-class bins, sequence flag, accepted-record counter.
    int mdl_cnt [16];
    int mdl_tog [16];
    bit mdl_seq;
    int mdl_n;
    bit cmp_en = 1'b0;

    // Dump observation, owned by the posedge monitor.
    int            emitted [16];
    int            cap_cnt [16];
    int            cap_tog [16];
    int            exp_idx;
    bit            hold_prev;
    logic [3:0]    prev_cls;
    logic [CW-1:0] prev_cnt, prev_tog;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mdl_clear();
        for (int k = 0; k < 16; k++) begin
            mdl_cnt[k] = 0;
            mdl_tog[k] = 0;
        end
        mdl_seq = 1'b0;
        mdl_n   = 0;
    endfunction

    function automatic void mdl_accept(input logic [3:0] pre, input logic [3:0] post,
                                       input logic yp, input logic yq);
        int k;
        logic [7:0] nb;
        k = int'({pre[3], pre[2], post[3], post[2]});
        if (mdl_cnt[k] < SatMax) mdl_cnt[k]++;
        if ((yp != yq) && (mdl_tog[k] < SatMax)) mdl_tog[k]++;
        nb = 8'(mdl_n);
        if ({pre, post} != nb) mdl_seq = 1'b1;
        mdl_n++;
    endfunction

    // Called at posedge+1; handshake decided by s_ready sampled before the edge.
    task automatic send(input logic [3:0] pre, input logic [3:0] post);
        logic rdy;
        s_valid    = 1'b1;
        s_pat_pre  = pre;
        s_pat_post = post;
        s_y_pre    = pre[3] ^ pre[2];
        s_y_post   = post[3] ^ post[2];
        rdy        = s_ready;
        @(posedge clk);
        if (rdy) mdl_accept(pre, post, s_y_pre, s_y_post);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        mdl_clear();
        #1;
        start = 1'b0;
    endtask

    task automatic run_dump(input bit stall5);
        int st = 0;
        int guard = 0;
        while (!done && guard < 200) begin
            @(negedge clk);
            guard++;
            if (m_valid && m_class == 4'd5 && stall5 && st < 3) begin
                m_ready = 1'b0;
                st++;
            end else begin
                m_ready = 1'b1;
            end
        end
        chk("dump_reaches_done", int'(done), 1);
        m_ready = 1'b0;
    endtask

    always @(posedge clk) begin
        hold_prev <= m_valid && !m_ready;
        prev_cls  <= m_class;
        prev_cnt  <= m_count;
        prev_tog  <= m_toggles;
        if (start) begin
            exp_idx <= 0;
            for (int k = 0; k < 16; k++) emitted[k] <= 0;
        end else if (m_valid && m_ready) begin
            exp_idx           <= exp_idx + 1;
            emitted[m_class]  <= emitted[m_class] + 1;
            cap_cnt[m_class]  <= int'(m_count);
            cap_tog[m_class]  <= int'(m_toggles);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            if (m_valid) begin
                chk("m_class", int'(m_class), exp_idx);
                chk("m_count", int'(m_count), mdl_cnt[m_class]);
                chk("m_toggles", int'(m_toggles), mdl_tog[m_class]);
                if (hold_prev) begin
                    chk("hold_class", int'(m_class), int'(prev_cls));
                    chk("hold_count", int'(m_count), int'(prev_cnt));
                    chk("hold_toggles", int'(m_toggles), int'(prev_tog));
                end
            end
            chk("seq_err", int'(seq_err), SeqEn ? int'(mdl_seq) : 0);
        end
    end

    initial begin
        int eb;
        int guard;
        start = 0; s_valid = 0; s_pat_pre = 0; s_pat_post = 0; s_y_pre = 0; s_y_post = 0;
        m_ready = 0;
        start_b = 0; s_valid_b = 0; s_pat_pre_b = 0; s_pat_post_b = 0; s_y_pre_b = 0;
        s_y_post_b = 0; m_ready_b = 0;
        exp_idx = 0;
        mdl_clear();
        #3;
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_seq_err", int'(seq_err), 0);
        chk("rst_m_class", int'(m_class), 0);
        chk("rst_m_count", int'(m_count), 0);
        chk("rst_m_toggles", int'(m_toggles), 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // s_valid in IDLE must not bin anything.
        s_valid = 1'b1; s_pat_pre = 4'h0; s_pat_post = 4'hF; s_y_pre = 1'b0; s_y_post = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("idle_busy", int'(busy), 0);

        // Campaign 1: full sweep, y = a^b, with a stray start in COLLECT.
        do_start();
        chk("collect_busy", int'(busy), 1);
        chk("collect_s_ready", int'(s_ready), 1);
        for (int n = 0; n < 256; n++) begin
            start = (n == 50);
            send(4'(n >> 4), 4'(n));
        end
        start = 1'b0;
        chk("dump_s_ready", int'(s_ready), 0);
        // s_valid during DUMP must be ignored.
        s_valid = 1'b1; s_pat_pre = 4'h0; s_pat_post = 4'h4; s_y_pre = 1'b0; s_y_post = 1'b1;
        run_dump(1'b1);
        s_valid = 1'b0;
        for (int k = 0; k < 16; k++) chk($sformatf("emitted_%0d", k), emitted[k], 1);
        @(negedge clk);
        chk("done_after_dump", int'(done), 1);
        chk("m_valid_after_dump", int'(m_valid), 0);
        chk("busy_after_dump", int'(busy), 0);
        chk("lit_count_c1", cap_cnt[1], 16);
        chk("lit_tog_c1", cap_tog[1], 16);
        chk("lit_count_c5", cap_cnt[5], 16);
        chk("lit_tog_c5", cap_tog[5], 0);
        chk("lit_tog_c6", cap_tog[6], 0);
        chk("lit_tog_c4", cap_tog[4], 16);

        // Campaign 2: aborted by reset after 100 records.
        @(posedge clk); #1;
        do_start();
        for (int n = 0; n < 100; n++) send(4'(n >> 4), 4'(n));
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_s_ready", int'(s_ready), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_m_valid", int'(m_valid), 0);
        mdl_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Campaign 3: record 17 out of order (post=2 instead of 1, same class).
        do_start();
        for (int n = 0; n < 256; n++) begin
            if (n == 17) send(4'd1, 4'd2);
            else         send(4'(n >> 4), 4'(n));
        end
        s_valid = 1'b0;
        run_dump(1'b0);
        for (int k = 0; k < 16; k++) chk($sformatf("post_abort_count_%0d", k), cap_cnt[k], 16);
        @(negedge clk);
        chk("final_seq_err", int'(seq_err), SeqEn ? 1 : 0);
        chk("final_done", int'(done), 1);

        // Small instance: NUM_EXP=4, CNT_W=2, four toggling records in class 3.
        @(posedge clk); #1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        s_valid_b = 1'b1;
        for (int n = 0; n < 4; n++) begin
            s_pat_pre_b  = 4'(n);
            s_pat_post_b = 4'hC | 4'(n);
            s_y_pre_b    = 1'b0;
            s_y_post_b   = 1'b1;
            @(posedge clk); #1;
        end
        s_valid_b = 1'b0;
        eb = 0;
        guard = 0;
        m_ready_b = 1'b1;
        while (!done_b && guard < 60) begin
            @(negedge clk);
            guard++;
            if (m_valid_b) begin
                chk($sformatf("b_count_%0d", m_class_b), int'(m_count_b),
                    (m_class_b == 4'd3) ? 3 : 0);
                chk($sformatf("b_tog_%0d", m_class_b), int'(m_toggles_b),
                    (m_class_b == 4'd3) ? 3 : 0);
                eb++;
            end
        end
        m_ready_b = 1'b0;
        chk("b_emitted", eb, 16);
        chk("b_done", int'(done_b), 1);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/correlation_2_collector.md
Name: correlation_2_collector

Overview:
- Receive-side companion to the 2-gate masked-gadget correlation stimulus.
- Accepts one record per experiment: the pre/post input patterns {a,b,r1,r2} and the sampled gadget output y before and after the transition.
- Bins toggle statistics by unmasked transition class {a_pre,b_pre,a_post,b_post}, independent of masks r1/r2.
- After NUM_EXP experiments, streams the 16 per-class results out for first-order leakage checks.

Parameters:
- NUM_EXP, 256, experiments per campaign; 16 pre patterns x 16 post patterns; range 1..65535.
- CNT_W, 16, width of each per-class counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a campaign.
- s_valid  in  1  experiment record valid.
- s_ready  out  1  collector accepts a record.
- s_pat_pre  in  4  {a,b,r1,r2} before the transition.
- s_pat_post  in  4  {a,b,r1,r2} after the transition.
- s_y_pre  in  1  gadget output sampled before the transition.
- s_y_post  in  1  gadget output sampled after the transition.
- m_valid  out  1  result record valid.
- m_ready  in  1  downstream accepts the result.
- m_class  out  4  class index {a_pre,b_pre,a_post,b_post}.
- m_count  out  CNT_W  experiments binned in the class.
- m_toggles  out  CNT_W  experiments in the class where y_pre != y_post.
- busy  out  1  high in COLLECT and DUMP.
- done  out  1  high in DONE.
- seq_err  out  1  sticky order-violation flag (only with the optional feature).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all counters, experiment counter and dump index cleared.
  - s_ready=0, m_valid=0, busy=0, done=0, seq_err=0; m_class/m_count/m_toggles=0.
- FSM states IDLE, COLLECT, DUMP, DONE.
- IDLE/DONE:
  - start moves to COLLECT next cycle.
  - All 16 count/toggle pairs and the experiment counter are cleared in that same edge; seq_err is also cleared.
  - start in COLLECT or DUMP is ignored.
- COLLECT:
  - s_ready=1 combinationally for the whole state.
  - On s_valid & s_ready: class k = {s_pat_pre[3:2], s_pat_post[3:2]}; count[k]++ and toggles[k] += s_y_pre ^ s_y_post.
  - Updated values are visible the cycle after the handshake.
  - Both counters saturate at all-ones and never wrap.
  - The experiment counter increments on each handshake.
  - The handshake that makes it equal NUM_EXP moves the FSM to DUMP on the same edge.
- DUMP:
  - m_valid=1 from the first DUMP cycle.
  - Dump index starts at 0; m_class=index, m_count/m_toggles are registered copies for that index.
  - Outputs hold stable while m_valid & !m_ready.
  - On m_ready, the index advances with no bubble.
  - Acceptance of class 15 moves to DONE; m_valid=0 next cycle.
  - s_ready=0 and s_valid is ignored.
- DONE: done=1; counters retained until the next start.
- s_valid outside COLLECT never alters state.
- rst_n asserted mid-campaign aborts immediately to IDLE with all counts cleared; there is no partial dump.

Optional Feature:
- Macro: CORR_SEQ_CHECK_EN.
- When defined, the block checks every accepted record against the campaign order: outer index i = pre pattern, inner index j = post pattern, experiment n carries pre = n[7:4], post = n[3:0].
- The first mismatch sets seq_err, which stays high until start or reset. Binning is unaffected.
- When undefined: no checker logic is built, and seq_err is tied 0.

Decomposition:
- Package corr_pkg:
  - NUM_CLASSES=16 and CLASS_W=4.
  - State enum {IDLE, COLLECT, DUMP, DONE}.
  - Function mapping (pat_pre, pat_post) to class index.
- One sub-module, corr_sat_counter: CNT_W-bit counter with clear, increment-enable and saturation. Instantiated 32 times (count and toggles per class).

Test Plan:
- Full sweep with y = a^b for all i,j (NUM_EXP=256): every class count=16. The toggles field is 16 where a_pre^b_pre != a_post^b_post, otherwise 0 (e.g. class 0b0001 ->16, 0b0101 ->0).
- m_ready held low for 3 cycles on class 5: m_class, m_count and m_toggles stable throughout; classes 0..15 each emitted exactly once; done high after class 15.
- NUM_EXP=4, CNT_W=2, four records all class 3 with toggles: count[3]=3 and toggles[3]=3 (saturated); all other classes 0.
- rst_n pulsed low after 100 records: s_ready=0 and busy=0 immediately. Then a new start plus 256 records yields per-class count=16, with no residue from the aborted run.
- CORR_SEQ_CHECK_EN with record 17 sent as pre=1, post=2 (expected pre=1, post=1): seq_err rises the cycle after that handshake and stays high through DONE. Without the macro, seq_err=0.
- start pulsed during COLLECT and s_valid pulsed during IDLE/DUMP: both ignored, with counts unchanged.
